// File: rtl/hps_dl_pkg.sv
// Shared types and widths for the HPS-style ioctl download sequencer.
package hps_dl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD,
        ST_FETCH,
        ST_WRITE,
        ST_GAP,
        ST_TAIL
    } hps_dl_state_e;

    localparam int ADDR_W  = 25;
    localparam int BYTE_W  = 8;
    localparam int WORD_W  = 16;
    localparam int TIMER_W = 16;

    // MSB index of ioctl_dout for the selected bus mode.
    function automatic int dout_msb(input int wide);
        return (wide != 0) ? WORD_W - 1 : BYTE_W - 1;
    endfunction

endpackage

// File: rtl/hps_dl_pack.sv
// Byte-to-beat packer: owns the source handshake and assembles 8- or 16-bit write beats.
module hps_dl_pack
    import hps_dl_pkg::*;
#(
    parameter int  WIDE = 0,
    localparam int DW   = dout_msb(WIDE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              arm,
    input  logic              two_left,
    input  logic              src_valid,
    input  logic [BYTE_W-1:0] src_data,
    output logic              src_ready,
    output logic              take,
    output logic              beat_done,
    output logic [DW:0]       dout
);

    logic              have_lo;
    logic [BYTE_W-1:0] lo_q;

    // Handshake: a byte moves on every clk edge where src_valid && src_ready;
    // src_ready is raised by arm and dropped on the edge that completes the beat.
    assign take      = src_valid && src_ready;
    assign beat_done = take && ((WIDE == 0) || have_lo || !two_left);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            src_ready <= 1'b0;
            have_lo   <= 1'b0;
            lo_q      <= '0;
            dout      <= '0;
        end else begin
            if (arm) begin
                src_ready <= 1'b1;
            end else if (beat_done) begin
                src_ready <= 1'b0;
            end

            if (take && !beat_done) begin
                lo_q    <= src_data;
                have_lo <= 1'b1;
            end

            // First byte lands in the low lane; an odd final byte leaves the high lane zero.
            if (beat_done) begin
                have_lo <= 1'b0;
                if (have_lo) begin
                    dout <= (DW + 1)'({src_data, lo_q});
                end else begin
                    dout <= (DW + 1)'(src_data);
                end
            end
        end
    end

endmodule

// File: rtl/hps_dl_seq.sv
// ARM->FPGA ioctl download sequencer: paces a byte stream onto the ioctl_* bus.
// Optional checksum output enabled by defining HPS_DL_CHECKSUM_EN.
module hps_dl_seq
    import hps_dl_pkg::*;
#(
    parameter int  WIDE   = 0,
    parameter int  WR_GAP = 3,
    parameter int  LEAD   = 2,
    parameter int  TAIL   = 2,
    localparam int DW     = dout_msb(WIDE)
) (
    input  logic              clk_sys,
    input  logic              rst_n,
    input  logic              start,
    input  logic [7:0]        index,
    input  logic [ADDR_W-1:0] length,
    input  logic              src_valid,
    input  logic [7:0]        src_data,
    output logic              src_ready,
    input  logic              ioctl_wait,
    output logic              ioctl_download,
    output logic [7:0]        ioctl_index,
    output logic              ioctl_wr,
    output logic [ADDR_W-1:0] ioctl_addr,
    output logic [DW:0]       ioctl_dout,
    output logic              busy,
    output logic              done,
    output hps_dl_state_e     dbg_state
`ifdef HPS_DL_CHECKSUM_EN
    ,
    output logic [15:0]       checksum
`endif
);

    localparam logic [ADDR_W-1:0]  ADDR_STEP = (WIDE != 0) ? ADDR_W'(2) : ADDR_W'(1);
    localparam logic [TIMER_W-1:0] LEAD_LAST = TIMER_W'(LEAD - 1);
    localparam logic [TIMER_W-1:0] TAIL_LAST = TIMER_W'(TAIL - 1);
    localparam logic [TIMER_W-1:0] GAP_LAST  = TIMER_W'((WR_GAP > 0) ? WR_GAP - 1 : 0);
    localparam bit                 HAS_GAP   = (WR_GAP > 0);

    hps_dl_state_e      state;
    logic [TIMER_W-1:0] timer;
    logic [ADDR_W-1:0]  length_q;
    logic [ADDR_W-1:0]  byte_cnt;
    logic [ADDR_W-1:0]  remaining;

    logic accept;
    logic take;
    logic beat_done;
    logic arm;
    logic all_taken;
    logic two_left;
    logic lead_exit;
    logic gap_exit;
    logic wr_exit;

    // A start coinciding with the done pulse is dropped so a finished download is always observable.
    assign accept    = (state == ST_IDLE) && start && !done;
    assign remaining = length_q - byte_cnt;
    assign all_taken = (byte_cnt == length_q);
    assign two_left  = (remaining > ADDR_W'(1));
    assign lead_exit = (state == ST_LEAD) && (timer == LEAD_LAST);
    assign gap_exit  = (state == ST_GAP) && !ioctl_wait && (timer == GAP_LAST);
    assign wr_exit   = (state == ST_WRITE) && ioctl_wr;

    // arm fires in the last cycle of every state that hands over to FETCH.
    assign arm = (lead_exit && (length_q != '0))
              || gap_exit
              || (wr_exit && !all_taken && !HAS_GAP);

    assign dbg_state = state;

    hps_dl_pack #(
        .WIDE(WIDE)
    ) u_pack (
        .clk      (clk_sys),
        .rst_n    (rst_n),
        .arm      (arm),
        .two_left (two_left),
        .src_valid(src_valid),
        .src_data (src_data),
        .src_ready(src_ready),
        .take     (take),
        .beat_done(beat_done),
        .dout     (ioctl_dout)
    );

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            timer          <= '0;
            length_q       <= '0;
            byte_cnt       <= '0;
            ioctl_download <= 1'b0;
            ioctl_index    <= '0;
            ioctl_wr       <= 1'b0;
            ioctl_addr     <= '0;
            busy           <= 1'b0;
            done           <= 1'b0;
        end else begin
            done <= 1'b0;
            if (take) begin
                byte_cnt <= byte_cnt + ADDR_W'(1);
            end

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state          <= ST_LEAD;
                        ioctl_index    <= index;
                        length_q       <= length;
                        byte_cnt       <= '0;
                        ioctl_addr     <= '0;
                        busy           <= 1'b1;
                        ioctl_download <= 1'b1;
                        timer          <= '0;
                    end
                end
                ST_LEAD: begin
                    if (lead_exit) begin
                        timer <= '0;
                        state <= (length_q == '0) ? ST_TAIL : ST_FETCH;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_FETCH: begin
                    if (beat_done) begin
                        state    <= ST_WRITE;
                        ioctl_wr <= !ioctl_wait;
                    end
                end
                // ioctl_wait is sampled one edge ahead, so the strobe never lands on a stalled cycle.
                ST_WRITE: begin
                    if (ioctl_wr) begin
                        ioctl_wr   <= 1'b0;
                        ioctl_addr <= ioctl_addr + ADDR_STEP;
                        timer      <= '0;
                        if (all_taken) begin
                            state <= ST_TAIL;
                        end else if (HAS_GAP) begin
                            state <= ST_GAP;
                        end else begin
                            state <= ST_FETCH;
                        end
                    end else if (!ioctl_wait) begin
                        ioctl_wr <= 1'b1;
                    end
                end
                ST_GAP: begin
                    if (gap_exit) begin
                        timer <= '0;
                        state <= ST_FETCH;
                    end else if (!ioctl_wait) begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                ST_TAIL: begin
                    if (timer == TAIL_LAST) begin
                        state          <= ST_IDLE;
                        ioctl_download <= 1'b0;
                        busy           <= 1'b0;
                        done           <= 1'b1;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef HPS_DL_CHECKSUM_EN
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            checksum <= '0;
        end else if (accept) begin
            checksum <= '0;
        end else if (take) begin
            checksum <= checksum + {8'h00, src_data};
        end
    end
`endif

endmodule
